// File: rtl/sig_delay_line.sv
// sig_delay_line: run-time tappable delay line for video sideband signals.
// Shifts on en, clears on reset/flush, and taps any stage 0..MAX_DEPTH
// combinationally. primed tells when the selected tap holds real history.
module sig_delay_line #(
  parameter int unsigned           WIDTH     = 2,
  parameter int unsigned           MAX_DEPTH = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  localparam int unsigned          DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    delay_sel,
  input  logic [WIDTH-1:0] sig_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] sig_out,
  output logic             valid_out,
  output logic             primed
);

  logic [WIDTH-1:0] d [1:MAX_DEPTH];
  logic             v [1:MAX_DEPTH];
  logic [DW-1:0]    fcnt;
  logic [DW-1:0]    eff;

  // Stage registers and fill counter: clear on reset/flush, shift on en, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
        d[k] <= RESET_VAL;
        v[k] <= 1'b0;
      end
      fcnt <= '0;
    end else if (flush) begin
      for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
        d[k] <= RESET_VAL;
        v[k] <= 1'b0;
      end
      fcnt <= '0;
    end else if (en) begin
      d[1] <= sig_in;
      v[1] <= valid_in;
      for (int unsigned k = 2; k <= MAX_DEPTH; k++) begin
        d[k] <= d[k-1];
        v[k] <= v[k-1];
      end
      if (fcnt != DW'(MAX_DEPTH)) begin
        fcnt <= fcnt + DW'(1);
      end
    end
  end

  // Clamp the requested delay to the physical depth.
  always_comb begin
    eff = delay_sel;
    if (delay_sel > DW'(MAX_DEPTH)) begin
      eff = DW'(MAX_DEPTH);
    end
  end

  // Tap mux: eff=0 bypasses the line, otherwise select stage eff.
  always_comb begin
    sig_out   = sig_in;
    valid_out = valid_in;
    for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
      if (eff == DW'(k)) begin
        sig_out   = d[k];
        valid_out = v[k];
      end
    end
  end

  // Primed once at least eff shifts have happened since the last clear.
  always_comb begin
    primed = (fcnt >= eff);
  end

endmodule

// File: doc/sig_delay_line.md
Name: sig_delay_line

Overview:
- Parametrised, run-time-tappable delay line for control/select signals in the VGA video pipeline.
- Realigns sideband signals (layer select, overlay enables) with pixel data whose path latency differs between modes.
- Adds the following beyond a fixed delay:
  - configurable width and maximum depth,
  - a run-time tap select,
  - a stall enable,
  - a synchronous flush,
  - valid tracking,
  - a primed indicator.

Parameters:
- WIDTH, 2, bit width of the delayed signal.
- MAX_DEPTH, 8, number of register stages (1..64); maximum selectable delay.
- RESET_VAL, 0, value loaded into every data stage on reset or flush (WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; the line shifts only when en=1 (stall when 0).
- flush  input  1  synchronous clear of all stages, valids and fill count.
- delay_sel  input  DW=$clog2(MAX_DEPTH+1)  requested delay in en-cycles, 0..MAX_DEPTH.
- sig_in  input  WIDTH  signal to delay.
- valid_in  input  1  qualifies sig_in.
- sig_out  output  WIDTH  delayed signal.
- valid_out  output  1  delayed valid.
- primed  output  1  high once at least the selected number of shifts has occurred since the last reset/flush.

Behaviour:
- Storage:
  - Stages d[1..MAX_DEPTH] of WIDTH bits, plus v[1..MAX_DEPTH] of 1 bit.
  - Fill counter fcnt of DW bits, saturating at MAX_DEPTH.
- Reset (asynchronous, reset=1):
  - d[*]=RESET_VAL, v[*]=0, fcnt=0.
  - Outputs immediately: sig_out=RESET_VAL (or sig_in if delay_sel=0), valid_out=0 (or valid_in if delay_sel=0), primed=0 (or 1 if delay_sel=0).
  - Reset dominates flush and en.
- Flush (flush=1, reset=0): on the clock edge, same clearing as reset. Flush dominates en, and the sig_in present in the flush cycle is discarded.
- Shift (en=1, flush=0):
  - d[1]<=sig_in, v[1]<=valid_in.
  - d[k]<=d[k-1] and v[k]<=v[k-1] for k=2..MAX_DEPTH.
  - fcnt<=min(fcnt+1, MAX_DEPTH).
- Stall (en=0, flush=0): all stages and fcnt hold.
- Tap (effective delay):
  - eff = min(delay_sel, MAX_DEPTH); out-of-range values clamp.
  - eff=0: sig_out=sig_in, valid_out=valid_in, purely combinational, zero latency.
  - eff=k≥1: sig_out=d[k], valid_out=v[k].
  - Latency is k en-cycles; with en tied high this is k clocks.
- Tap mux is combinational on delay_sel:
  - A delay_sel change takes effect in the same cycle, with no re-priming.
  - The output may repeat or skip samples at the switch. This is defined behaviour; upstream changes delay_sel only during vertical blanking.
- primed = (fcnt >= eff), combinational from registered fcnt.
  - Indicates that sig_out holds real history rather than reset fill.
  - valid_out is independent of primed; valid_out only reflects valid_in history.
- fcnt wrap: never wraps; it holds at MAX_DEPTH on further shifts.
- No internal clock gating. en is a data-path enable only.

Test Plan:
- WIDTH=2, MAX_DEPTH=8, delay_sel=4, en=1, sig_in sequence 1,2,3,0,1…, valid_in=1:
  - sig_out reproduces the sequence exactly 4 clocks later; valid_out rises 4 clocks after valid_in.
  - primed rises on the 4th clock edge after reset release.
- delay_sel=0: sig_in=3 with valid_in=1 → sig_out=3 and valid_out=1 in the same cycle, with no clock edge. primed=1 immediately after reset.
- delay_sel=8, drive sig_in=2 for one en-cycle then 0; hold en=0 for 5 clocks midway:
  - The 2 appears at sig_out after exactly 8 en=1 cycles; the stalled clocks do not count.
  - fcnt saturates at 8 and stays there.
- delay_sel=15 (out of range) → behaves identically to delay_sel=8.
- Pipeline primed with data at delay_sel=3; assert flush for one cycle together with en=1 and sig_in=1:
  - Next cycle sig_out=RESET_VAL, valid_out=0, primed=0.
  - The flushed-cycle input never appears at the output.
- Assert reset asynchronously mid-stream between clock edges:
  - sig_out=RESET_VAL and valid_out=0 before the next clk edge.
  - After release, 3 shifts are needed before primed=1 (delay_sel=3).
